// File: rtl/mul_signed_arb.sv
// mul_signed_arb: NREQ requesters share one 8x8 signed multiplier through a
// round-robin arbiter and a two-stage pipeline (operand capture, product).
// Optional per-requester grant counters: define MUL_SIGNED_ARB_STATS_EN.
`timescale 1ns/1ps
module mul_signed_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [8*NREQ-1:0]  req_a,
  input  logic [8*NREQ-1:0]  req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_z,
  output logic [IDW-1:0]     rsp_id,
`ifdef MUL_SIGNED_ARB_STATS_EN
  input  logic               clr_stats,
  output logic [16*NREQ-1:0] grant_cnt,
`endif
  output logic               busy
);

  // Full-precision signed product; both operands sign-extended to 16 bits,
  // so the low 16 bits of the product are exact for every 8-bit input.
  function automatic logic [15:0] mul_signed(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ax;
    logic signed [15:0] bx;
    logic signed [15:0] p;
    ax = {{8{a[7]}}, a};
    bx = {{8{b[7]}}, b};
    p  = ax * bx;
    return p;
  endfunction

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            s0_vld_q, s0_vld_d;
  logic [7:0]      s0_a_q, s0_a_d;
  logic [7:0]      s0_b_q, s0_b_d;
  logic [IDW-1:0]  s0_id_q, s0_id_d;
  logic            s1_vld_q, s1_vld_d;
  logic [15:0]     s1_z_q, s1_z_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;

  logic            found_s;
  logic [NREQ-1:0] gnt_oh_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic [IDW-1:0]  gnt_nxt_s;
  logic [7:0]      gnt_a_s;
  logic [7:0]      gnt_b_s;
  logic            adv0_s;
  logic            adv1_s;
  logic            take_s;

  // Round-robin pick: the valid requester closest to rr_ptr (modulo NREQ) wins.
  always_comb begin
    int best_d;
    int d;
    best_d    = NREQ;
    d         = 0;
    gnt_oh_s  = '0;
    gnt_idx_s = '0;
    gnt_nxt_s = '0;
    gnt_a_s   = 8'h00;
    gnt_b_s   = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(rr_ptr_q);
      if (d < 0) begin
        d = d + NREQ;
      end else begin
        d = d;
      end
      if (req_valid[i] && (d < best_d)) begin
        best_d      = d;
        gnt_oh_s    = '0;
        gnt_oh_s[i] = 1'b1;
        gnt_idx_s   = IDW'(i);
        gnt_nxt_s   = IDW'((i + 1) % NREQ);
        gnt_a_s     = req_a[8*i +: 8];
        gnt_b_s     = req_b[8*i +: 8];
      end else begin
        best_d = best_d;
      end
    end
    found_s = (best_d < NREQ);
  end

  // Pipeline advance conditions, grant qualification and next-state for both stages.
  always_comb begin
    adv1_s   = !s1_vld_q || rsp_ready;
    adv0_s   = !s0_vld_q || adv1_s;
    take_s   = adv0_s && found_s;
    rr_ptr_d = rr_ptr_q;
    s0_vld_d = s0_vld_q;
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    s0_id_d  = s0_id_q;
    s1_vld_d = s1_vld_q;
    s1_z_d   = s1_z_q;
    s1_id_d  = s1_id_q;
    if (take_s) begin
      rr_ptr_d = gnt_nxt_s;
      s0_vld_d = 1'b1;
      s0_a_d   = gnt_a_s;
      s0_b_d   = gnt_b_s;
      s0_id_d  = gnt_idx_s;
    end else if (adv0_s) begin
      s0_vld_d = 1'b0;
    end else begin
      s0_vld_d = s0_vld_q;
    end
    if (adv1_s) begin
      s1_vld_d = s0_vld_q;
      s1_z_d   = mul_signed(s0_a_q, s0_b_q);
      s1_id_d  = s0_id_q;
    end else begin
      s1_vld_d = s1_vld_q;
    end
  end

  // Pipeline and arbitration state; reset discards all in-flight entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      s0_vld_q <= 1'b0;
      s0_a_q   <= 8'h00;
      s0_b_q   <= 8'h00;
      s0_id_q  <= '0;
      s1_vld_q <= 1'b0;
      s1_z_q   <= 16'h0000;
      s1_id_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s0_vld_q <= s0_vld_d;
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      s0_id_q  <= s0_id_d;
      s1_vld_q <= s1_vld_d;
      s1_z_q   <= s1_z_d;
      s1_id_q  <= s1_id_d;
    end
  end

  // Grant is held off while reset is asserted so no requester sees an accept.
  assign req_ready = (take_s && !rst) ? gnt_oh_s : '0;
  assign rsp_valid = s1_vld_q;
  assign rsp_z     = s1_z_q;
  assign rsp_id    = s1_id_q;
  assign busy      = s0_vld_q | s1_vld_q;

`ifdef MUL_SIGNED_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q, cnt_d;

  // Saturating per-requester accept counters; clear beats a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (clr_stats) begin
        cnt_d[i] = 16'h0000;
      end else if (take_s && gnt_oh_s[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'h0001;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mul_signed_arb.sv
// Scoreboard bench for mul_signed_arb: accepted requests push hand-computed
// products; an independent monitor pops and compares each presented response.
`timescale 1ns/1ps
module tb_mul_signed_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_z;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
`ifdef MUL_SIGNED_ARB_STATS_EN
  logic              clr_stats;
  logic [16*NREQ-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  mul_signed_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id),
`ifdef MUL_SIGNED_ARB_STATS_EN
    .clr_stats(clr_stats), .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    int          id;
    logic [15:0] z;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_rsp = 0;
  int          n_acc = 0;
  int          n_drop = 0;
  logic [7:0]  va [NREQ][8];
  logic [7:0]  vb [NREQ][8];
  logic [15:0] vz [NREQ][8];
  int          vcnt [NREQ];
  int          vptr [NREQ];
  int          gcount [NREQ];
  bit          lat_chk;
  bit          ord_chk;
  int          ord_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_vecs();
    for (int i = 0; i < NREQ; i++) begin
      vcnt[i] = 0;
      vptr[i] = 0;
      gcount[i] = 0;
    end
  endtask

  task automatic put(input int r, input int a, input int b, input logic [15:0] z);
    va[r][vcnt[r]] = 8'(a);
    vb[r][vcnt[r]] = 8'(b);
    vz[r][vcnt[r]] = z;
    vcnt[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (vptr[i] < vcnt[i]) begin
        req_valid[i]   = 1'b1;
        req_a[8*i +: 8] = va[i][vptr[i]];
        req_b[8*i +: 8] = vb[i][vptr[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // One clock: sample accepts at the falling edge, then update requesters after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id  = i;
        e.z   = vz[i][vptr[i]];
        e.cyc = cyc;
        e.lat = lat_chk;
        sbq.push_back(e);
        gcount[i]++;
        n_acc++;
        if (ord_chk) begin
          chk("rr_order", 32'(i), 32'(ord_exp));
          ord_exp = (i + 1) % NREQ;
        end
        vptr[i]++;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && !rst) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d z 0x%0h, expected no response", rsp_id, rsp_z);
        end else begin
          e = sbq.pop_front();
          n_rsp++;
          chk("rsp_z", 32'(rsp_z), 32'(e.z));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]    hold_z;
    logic [IDW-1:0] hold_id;
    bit             have;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
`ifdef MUL_SIGNED_ARB_STATS_EN
    clr_stats = 1'b0;
`endif
    lat_chk = 1'b1;
    ord_chk = 1'b0;
    ord_exp = 0;
    clear_vecs();

    // Reset state, with requesters asserting valid during reset.
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request from requester 2: -3 * 7 = -21.
    clear_vecs();
    put(2, -3, 7, 16'hFFEB);
    drive();
    run(6);
    chk("single_grants", 32'(gcount[2]), 32'd1);
    chk("single_drain", 32'(sbq.size()), 32'd0);

    // Corner products back-to-back from requester 0.
    clear_vecs();
    put(0, -128, -128, 16'h4000);
    put(0, -128, 127, 16'hC080);
    put(0, 127, 127, 16'h3F01);
    put(0, 0, -1, 16'h0000);
    drive();
    run(4);
    chk("corner_back_to_back", 32'(gcount[0]), 32'd4);
    run(4);
    chk("corner_drain", 32'(sbq.size()), 32'd0);

    // Reset mid-flight with both stages full.
    clear_vecs();
    put(0, 3, -4, 16'hFFF4);
    put(1, -5, -6, 16'h001E);
    put(2, 64, 2, 16'h0080);
    put(3, -128, 1, 16'hFF80);
    rsp_ready = 1'b0;
    drive();
    run(3);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    n_drop = sbq.size();
    sbq.delete();
    clear_vecs();
    req_valid = '0;
    @(negedge clk) rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin with all requesters valid; first grant must be requester 0.
    put(0, 2, 3, 16'h0006);     put(0, -1, -1, 16'h0001);   put(0, 10, -10, 16'hFF9C);
    put(1, 5, 5, 16'h0019);     put(1, -2, 64, 16'hFF80);   put(1, 100, 100, 16'h2710);
    put(2, -7, 9, 16'hFFC1);    put(2, 127, -128, 16'hC080); put(2, 1, -128, 16'hFF80);
    put(3, 12, -12, 16'hFF70);  put(3, 0, 55, 16'h0000);    put(3, -100, -100, 16'h2710);
    ord_chk = 1'b1;
    ord_exp = 0;
    drive();
    run(16);
    ord_chk = 1'b0;
    for (int i = 0; i < NREQ; i++) chk("rr_grants", 32'(gcount[i]), 32'd3);
    chk("rr_drain", 32'(sbq.size()), 32'd0);

`ifdef MUL_SIGNED_ARB_STATS_EN
    chk("stats_req1", 32'(grant_cnt[31:16]), 32'd3);
    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    chk("stats_clr_req1", 32'(grant_cnt[31:16]), 32'd0);
    chk("stats_clr_req3", 32'(grant_cnt[63:48]), 32'd0);
`endif

    // Backpressure: rsp_ready low for 5 cycles with all requesters valid.
    clear_vecs();
    put(0, 3, -4, 16'hFFF4);
    put(1, -5, -6, 16'h001E);
    put(2, 64, 2, 16'h0080);
    put(3, -128, 1, 16'hFF80);
    lat_chk = 1'b0;
    rsp_ready = 1'b0;
    have = 1'b0;
    hold_z = 16'h0000;
    hold_id = '0;
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      #1;
      if (rsp_valid) begin
        if (!have) begin
          have = 1'b1;
          hold_z = rsp_z;
          hold_id = rsp_id;
        end else begin
          chk("bp_z_stable", 32'(rsp_z), 32'(hold_z));
          chk("bp_id_stable", 32'(rsp_id), 32'(hold_id));
        end
      end
    end
    chk("bp_accepts", 32'(gcount[0] + gcount[1] + gcount[2] + gcount[3]), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    run(8);
    for (int i = 0; i < NREQ; i++) chk("bp_grants", 32'(gcount[i]), 32'd1);
    chk("bp_drain", 32'(sbq.size()), 32'd0);
    chk("rsp_count", 32'(n_rsp), 32'(n_acc - n_drop));
    chk("idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_signed_arb.md
Name: mul_signed_arb

Overview:
- Shares one 8x8 signed combinational multiplier (`mul_signed`, a/b 8-bit two's complement -> z 16-bit) between NREQ requesters.
- Round-robin arbitration with a 2-stage registered pipeline: operand capture, then multiply and result register.
- Per-request ID tag returned with the product; single shared response port with backpressure.
- Sits between DSP-style clients and the multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
- req_a  input  8*NREQ  signed multiplicand; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  signed multiplier; same slicing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_z  output  16  signed product a*b.
- rsp_id  output  IDW  index of the requester that issued the product.
- busy  output  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Reset (async, rst=1):
  - s0_vld=0, s1_vld=0, rr_ptr=0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_z=0, rsp_id=0, busy=0.
  - Reset mid-operation discards all in-flight entries; no response is produced for them.
- Handshakes:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A response is consumed when rsp_valid && rsp_ready.
  - Requesters must hold req_valid/req_a/req_b stable until accepted.
- Arbitration (combinational from registered state):
  - adv1 = !s1_vld || rsp_ready.
  - adv0 = !s0_vld || adv1.
  - When adv0=1, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ. req_ready = one-hot of that i.
  - When adv0=0, or no requester is valid, req_ready=0.
  - On a grant to i: rr_ptr <= (i+1) mod NREQ. Otherwise rr_ptr holds.
  - A requester holding valid is granted within NREQ accepting cycles (starvation-free).
- Stage 0, on a grant when adv0=1: s0_a, s0_b, s0_id <= granted operands and index; s0_vld <= 1.
  - If adv0=1 and no grant: s0_vld <= 0.
  - If adv0=0: hold.
- Stage 1, when adv1=1: s1_z <= mul_signed(s0_a, s0_b); s1_id <= s0_id; s1_vld <= s0_vld.
  - Otherwise hold.
  - rsp_z, rsp_id and rsp_valid drive directly from s1_z, s1_id and s1_vld.
  - rsp_z/rsp_id hold their last value while rsp_valid=0.
- Latency: accept at edge T -> rsp_valid=1 after edge T+1, presentable in the cycle after T+1.
- Throughput: one product per cycle with no backpressure.
- Backpressure:
  - rsp_valid && !rsp_ready freezes stage 1 and rsp_* (values stable).
  - Stage 0 still fills if empty; then req_ready=0 until the stall clears.
  - Maximum in-flight is 2; no request is lost or duplicated.
- Arithmetic: full-precision signed product, 16-bit, never overflows.
  - Corner cases: -128 * -128 = +16384 (0x4000); -128 * 127 = -16256 (0xC080).
- busy = s0_vld | s1_vld.

Optional Feature:
- Macro: MUL_SIGNED_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt, 16*NREQ bits; counter i occupies [16i+15:16i].
  - Counter i increments on every accepted transfer from requester i and saturates at 0xFFFF.
  - Counters reset to 0 on rst.
  - Adds input clr_stats (1 bit), which synchronously zeroes all counters. clr_stats wins over a same-cycle increment.
- Not defined: neither port exists; no counter logic is generated. Datapath behaviour is identical either way.

Test Plan:
- Single request: requester 2 sends a=-3, b=7 (others idle, rsp_ready=1).
  - req_ready[2] pulses once.
  - Two edges later: rsp_valid=1, rsp_z=0xFFEB (-21), rsp_id=2.
- Corner products, back-to-back from requester 0: (-128,-128), (-128,127), (127,127), (0,-1).
  - Responses in order on consecutive cycles: 0x4000, 0xC080, 0x3F01, 0x0000.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1.
  - Grant order 0,1,2,3,0,1...
  - rsp_id follows the same sequence with no gaps.
- Backpressure: all 4 requesters valid, rsp_ready held 0 for 5 cycles.
  - Exactly 2 accepts occur; then req_ready=0.
  - rsp_z/rsp_id stay stable.
  - After release, responses resume with no loss or duplication.
- Reset mid-flight: assert rst asynchronously with both stages full.
  - Outputs go to reset values immediately, busy=0, rr_ptr=0.
  - After deassert, the first grant goes to the lowest valid index.
- Stats (MUL_SIGNED_ARB_STATS_EN defined):
  - 3 accepts from requester 1 -> grant_cnt[31:16]=3.
  - Assert clr_stats for 1 cycle -> 0.
  - Preload near saturation -> holds at 0xFFFF.
